// File: rtl/recon_stream_capture_if.sv
// AXI-Stream bundle used for the ingress frame port and the stripped payload port.
interface recon_stream_capture_if #(
  parameter int DATA_WIDTH = 512
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/recon_stream_capture.sv
// Multi-slot reconfiguration capture: parses the recon header of each frame, strips it, forwards
// payload, tracks per-slot bitstream completion and issues write/load commands.
module recon_stream_capture #(
  parameter int          DATA_WIDTH       = 512,
  parameter int          KEEP_WIDTH       = DATA_WIDTH / 8,
  parameter int          ADDR_WIDTH       = 34,
  parameter int          HDR_OFFSET       = 46,
  parameter int          NUM_SLOTS        = 4,
  parameter logic [63:0] BASE_ADDR        = 64'd0,
  parameter int          SLOT_STRIDE_LOG2 = 24
) (
  input  logic                   s_axis_clk,
  input  logic                   rst,
  recon_stream_capture_if.slave  s_axis,
  recon_stream_capture_if.master m_axis,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_op,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic [31:0]            cmd_len,
  output logic [NUM_SLOTS-1:0]   slot_valid,
  output logic                   done,
  output logic                   err_overrun,
  output logic                   err_drop,
  output logic [15:0]            drop_count
);

  localparam int STRIP_BYTES = HDR_OFFSET + 8;
  localparam int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic [31:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      n = n + {31'd0, k[i]};
    end
    return n;
  endfunction

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   m_tdata_r;
  logic [KEEP_WIDTH-1:0]   m_tkeep_r;
  logic                    m_tlast_r;
  logic                    m_tvalid_r;
  logic                    cmd_valid_r;
  logic                    cmd_op_r;
  logic [ADDR_WIDTH-1:0]   cmd_addr_r;
  logic [31:0]             cmd_len_r;
  logic [NUM_SLOTS-1:0]    slot_valid_r;
  logic [31:0]             slot_size_r [NUM_SLOTS];
  logic                    active_r;
  logic [SLOT_W-1:0]       active_id_r;
  logic [31:0]             active_size_r;
  logic [31:0]             remaining_r;
  logic                    done_r;
  logic                    err_overrun_r;
  logic                    err_drop_r;
  logic [15:0]             drop_count_r;

  logic [1:0]              func_s;
  logic [7:0]              hid_s;
  logic                    size_valid_s;
  logic [31:0]             size_s;
  logic [SLOT_W-1:0]       slot_s;
  logic                    id_ok_s;
  logic                    hdr_write_s;
  logic                    hdr_cont_s;
  logic                    hdr_load_s;
  logic [ADDR_WIDTH-1:0]   slot_addr_s;

  logic                    out_free_s;
  logic                    ready_s;
  logic                    in_ready_s;
  logic                    beat_s;
  logic                    is_hdr_s;
  logic [DATA_WIDTH-1:0]   fwd_data_s;
  logic [KEEP_WIDTH-1:0]   fwd_keep_s;
  logic                    fwd_en_s;
  logic                    emit_s;
  logic [31:0]             cnt_s;
  logic                    count_en_s;
  logic                    stray_s;
  logic [31:0]             rem_base_s;
  logic [SLOT_W-1:0]       tgt_slot_s;
  logic [31:0]             tgt_size_s;

  assign func_s       = s_axis.tdata[HDR_OFFSET*8 +: 2];
  assign hid_s        = s_axis.tdata[HDR_OFFSET*8+2 +: 8];
  assign size_valid_s = s_axis.tdata[HDR_OFFSET*8+31];
  assign size_s       = s_axis.tdata[HDR_OFFSET*8+32 +: 32];
  assign slot_s       = hid_s[SLOT_W-1:0];
  assign id_ok_s      = ({1'b0, hid_s} < 9'(NUM_SLOTS));
  assign slot_addr_s  = ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(slot_s) << SLOT_STRIDE_LOG2);

  // Header classification; a continuation must match the write still in progress.
  always_comb begin
    hdr_write_s = (func_s == 2'b00) && size_valid_s && id_ok_s;
    hdr_cont_s  = (func_s == 2'b00) && !size_valid_s && id_ok_s && active_r &&
                  (hid_s == 8'(active_id_r)) && (remaining_r != 32'd0);
    hdr_load_s  = (func_s == 2'b01) && id_ok_s && slot_valid_r[slot_s];
  end

  // Ingress handshake, header stripping and byte accounting for the beat in flight.
  always_comb begin
    out_free_s = !m_tvalid_r || m_axis.tready;
    case (state_r)
      ST_HDR:  ready_s = out_free_s && !(cmd_valid_r && !cmd_ready);
      ST_FWD:  ready_s = out_free_s;
      ST_DROP: ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
    in_ready_s = ready_s && !rst;
    beat_s     = s_axis.tvalid && in_ready_s;
    is_hdr_s   = (state_r == ST_HDR);

    if (is_hdr_s) begin
      fwd_data_s = s_axis.tdata >> (STRIP_BYTES * 8);
      fwd_keep_s = s_axis.tkeep >> STRIP_BYTES;
    end else begin
      fwd_data_s = s_axis.tdata;
      fwd_keep_s = s_axis.tkeep;
    end

    fwd_en_s   = (is_hdr_s && (hdr_write_s || hdr_cont_s)) || (state_r == ST_FWD);
    emit_s     = beat_s && fwd_en_s && (fwd_keep_s != {KEEP_WIDTH{1'b0}});
    cnt_s      = popcount(fwd_keep_s);
    count_en_s = beat_s && fwd_en_s && (is_hdr_s || active_r);
    // Bytes arriving after the active write already finished or overran.
    stray_s    = beat_s && (state_r == ST_FWD) && !active_r && (cnt_s != 32'd0);

    if (is_hdr_s && hdr_write_s) begin
      rem_base_s = size_s;
      tgt_slot_s = slot_s;
      tgt_size_s = size_s;
    end else begin
      rem_base_s = remaining_r;
      tgt_slot_s = active_id_r;
      tgt_size_s = active_size_r;
    end
  end

  // Payload output register; holds while the downstream stalls.
  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      m_tdata_r  <= {DATA_WIDTH{1'b0}};
      m_tkeep_r  <= {KEEP_WIDTH{1'b0}};
      m_tlast_r  <= 1'b0;
      m_tvalid_r <= 1'b0;
    end else begin
      if (m_axis.tready) begin
        m_tvalid_r <= 1'b0;
      end
      if (emit_s) begin
        m_tdata_r  <= fwd_data_s;
        m_tkeep_r  <= fwd_keep_s;
        m_tlast_r  <= s_axis.tlast;
        m_tvalid_r <= 1'b1;
      end
    end
  end

  // Frame FSM with command, slot bookkeeping and error outputs.
  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      state_r       <= ST_HDR;
      cmd_valid_r   <= 1'b0;
      cmd_op_r      <= 1'b0;
      cmd_addr_r    <= {ADDR_WIDTH{1'b0}};
      cmd_len_r     <= 32'd0;
      slot_valid_r  <= {NUM_SLOTS{1'b0}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_size_r[i] <= 32'd0;
      end
      active_r      <= 1'b0;
      active_id_r   <= {SLOT_W{1'b0}};
      active_size_r <= 32'd0;
      remaining_r   <= 32'd0;
      done_r        <= 1'b0;
      err_overrun_r <= 1'b0;
      err_drop_r    <= 1'b0;
      drop_count_r  <= 16'd0;
    end else begin
      done_r <= 1'b0;
      if (cmd_ready) begin
        cmd_valid_r <= 1'b0;
      end
      if (beat_s) begin
        case (state_r)
          ST_HDR: begin
            if (hdr_write_s) begin
              cmd_valid_r           <= 1'b1;
              cmd_op_r              <= 1'b0;
              cmd_addr_r            <= slot_addr_s;
              cmd_len_r             <= size_s;
              slot_valid_r[slot_s]  <= 1'b0;
              active_r              <= 1'b1;
              active_id_r           <= slot_s;
              active_size_r         <= size_s;
              state_r               <= s_axis.tlast ? ST_HDR : ST_FWD;
            end else if (hdr_cont_s) begin
              state_r <= s_axis.tlast ? ST_HDR : ST_FWD;
            end else if (hdr_load_s) begin
              cmd_valid_r <= 1'b1;
              cmd_op_r    <= 1'b1;
              cmd_addr_r  <= slot_addr_s;
              cmd_len_r   <= slot_size_r[slot_s];
              state_r     <= s_axis.tlast ? ST_HDR : ST_DROP;
            end else begin
              err_drop_r <= 1'b1;
              if (drop_count_r != 16'hFFFF) begin
                drop_count_r <= drop_count_r + 16'd1;
              end
              state_r <= s_axis.tlast ? ST_HDR : ST_DROP;
            end
          end
          ST_FWD:  state_r <= s_axis.tlast ? ST_HDR : ST_FWD;
          ST_DROP: state_r <= s_axis.tlast ? ST_HDR : ST_DROP;
          default: state_r <= ST_HDR;
        endcase

        // Later assignments here override the header defaults above.
        if (count_en_s) begin
          if (cnt_s > rem_base_s) begin
            err_overrun_r <= 1'b1;
            remaining_r   <= 32'd0;
            active_r      <= 1'b0;
          end else if (cnt_s == rem_base_s) begin
            slot_valid_r[tgt_slot_s] <= 1'b1;
            slot_size_r[tgt_slot_s]  <= tgt_size_s;
            done_r                   <= 1'b1;
            remaining_r              <= 32'd0;
            active_r                 <= 1'b0;
          end else begin
            remaining_r <= rem_base_s - cnt_s;
          end
        end else if (stray_s) begin
          err_overrun_r <= 1'b1;
        end
      end
    end
  end

  assign s_axis.tready = in_ready_s;
  assign m_axis.tdata  = m_tdata_r;
  assign m_axis.tkeep  = m_tkeep_r;
  assign m_axis.tlast  = m_tlast_r;
  assign m_axis.tvalid = m_tvalid_r;
  assign cmd_valid     = cmd_valid_r;
  assign cmd_op        = cmd_op_r;
  assign cmd_addr      = cmd_addr_r;
  assign cmd_len       = cmd_len_r;
  assign slot_valid    = slot_valid_r;
  assign done          = done_r;
  assign err_overrun   = err_overrun_r;
  assign err_drop      = err_drop_r;
  assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_recon_stream_capture.sv
// Directed bench for recon_stream_capture: header parsing, payload stripping, slot tracking and stalls.
module tb_recon_stream_capture;

  localparam logic [79:0]  PAY1 = 80'hA9A8_A7A6_A5A4_A3A2_A1A0;
  localparam logic [79:0]  PAY2 = 80'h5958_5756_5554_5352_5150;
  localparam logic [63:0]  ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [511:0] D1   = {8{64'h1111_2222_3333_4444}};
  localparam logic [511:0] D2   = {8{64'hDEAD_BEEF_0123_4567}};

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op, done, err_overrun, err_drop;
  logic [33:0] cmd_addr;
  logic [31:0] cmd_len;
  logic [3:0]  slot_valid;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [511:0] mq_data [$];
  logic [63:0]  mq_keep [$];
  logic         mq_last [$];
  logic         cq_op   [$];
  logic [33:0]  cq_addr [$];
  logic [31:0]  cq_len  [$];

  recon_stream_capture_if #(.DATA_WIDTH(512)) s_if ();
  recon_stream_capture_if #(.DATA_WIDTH(512)) m_if ();

  recon_stream_capture #(
    .DATA_WIDTH(512), .KEEP_WIDTH(64), .ADDR_WIDTH(34), .HDR_OFFSET(46),
    .NUM_SLOTS(4), .BASE_ADDR(64'd0), .SLOT_STRIDE_LOG2(24)
  ) dut (
    .s_axis_clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .slot_valid(slot_valid), .done(done), .err_overrun(err_overrun),
    .err_drop(err_drop), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Monitor samples one time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      mq_data.push_back(m_if.tdata);
      mq_keep.push_back(m_if.tkeep);
      mq_last.push_back(m_if.tlast);
    end
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      cq_op.push_back(cmd_op);
      cq_addr.push_back(cmd_addr);
      cq_len.push_back(cmd_len);
    end
    if (done === 1'b1) done_cnt++;
  end

  function automatic logic [63:0] mk_hdr(input logic [1:0] f, input logic [7:0] id,
                                         input logic sv, input logic [31:0] sz);
    return {sz, sv, 21'd0, id, f};
  endfunction

  function automatic logic [511:0] first_beat(input logic [63:0] h, input logic [79:0] pay);
    logic [511:0] d;
    d = 512'd0;
    d[431:368] = h;
    d[511:432] = pay;
    return d;
  endfunction

  task automatic clear_q();
    mq_data.delete(); mq_keep.delete(); mq_last.delete();
    cq_op.delete(); cq_addr.delete(); cq_len.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tvalid = 1'b1;
    #1;
    while (s_if.tready !== 1'b1 && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: tready=%b after %0d cycles, required 1", s_if.tready, guard);
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_mvalid: got %b want 0", m_if.tvalid); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd: got %b want 0", cmd_valid); end
    checks++; if (slot_valid !== 4'b0000) begin errors++; $display("FAIL rst_slot: got %b want 0000", slot_valid); end
    checks++; if ({done, err_overrun, err_drop} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {done, err_overrun, err_drop}); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_dropcnt: got %0d want 0", drop_count); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %b want 1", s_if.tready); end
  endtask

  task automatic test_write_header();
    logic [511:0] exp;
    exp = 512'd0;
    exp[79:0] = PAY1;
    clear_q();
    send_beat(first_beat(mk_hdr(2'd0, 8'd1, 1'b1, 32'd100), PAY1), ALL, 1'b0);
    idle(3);
    checks++;
    if (cq_op.size() != 1) begin errors++; $display("FAIL wr_cmd_count: got %0d want 1", cq_op.size()); end
    else if ({cq_op[0], cq_addr[0], cq_len[0]} !== {1'b0, 34'h100_0000, 32'd100}) begin
      errors++; $display("FAIL wr_cmd: got op=%b addr=%h len=%0d want op=0 addr=1000000 len=100", cq_op[0], cq_addr[0], cq_len[0]);
    end
    checks++;
    if (mq_keep.size() != 1) begin errors++; $display("FAIL wr_beats: got %0d want 1", mq_keep.size()); end
    else if (mq_keep[0] !== 64'h3FF || mq_data[0] !== exp || mq_last[0] !== 1'b0) begin
      errors++; $display("FAIL wr_first_beat: got keep=%h last=%b data=%h want keep=3ff last=0", mq_keep[0], mq_last[0], mq_data[0][79:0]);
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL wr_no_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_complete_and_load();
    clear_q();
    send_beat(D1, ALL, 1'b0);
    send_beat(D2, 64'h0000_0000_03FF_FFFF, 1'b1);
    idle(3);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL cpl_done: got %0d pulses want 1", done_cnt); end
    checks++; if (slot_valid !== 4'b0010) begin errors++; $display("FAIL cpl_slot: got %b want 0010", slot_valid); end
    checks++;
    if (mq_keep.size() != 2) begin errors++; $display("FAIL cpl_beats: got %0d want 2", mq_keep.size()); end
    else if (mq_data[0] !== D1 || mq_keep[1] !== 64'h3FF_FFFF || mq_last[1] !== 1'b1) begin
      errors++; $display("FAIL cpl_tail: got keep=%h last=%b want keep=3ffffff last=1", mq_keep[1], mq_last[1]);
    end
    clear_q();
    send_beat(first_beat(mk_hdr(2'd1, 8'd1, 1'b0, 32'd0), PAY2), ALL, 1'b0);
    send_beat(D1, ALL, 1'b1);
    idle(3);
    checks++;
    if (cq_op.size() != 1) begin errors++; $display("FAIL ld_cmd_count: got %0d want 1", cq_op.size()); end
    else if ({cq_op[0], cq_addr[0], cq_len[0]} !== {1'b1, 34'h100_0000, 32'd100}) begin
      errors++; $display("FAIL ld_cmd: got op=%b addr=%h len=%0d want op=1 addr=1000000 len=100", cq_op[0], cq_addr[0], cq_len[0]);
    end
    checks++; if (mq_keep.size() != 0) begin errors++; $display("FAIL ld_no_payload: got %0d beats want 0", mq_keep.size()); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL ld_no_drop: got %b want 0", err_drop); end
  endtask

  task automatic test_drop();
    clear_q();
    send_beat(first_beat(mk_hdr(2'd2, 8'd1, 1'b1, 32'd8), PAY1), ALL, 1'b0);
    send_beat(D1, ALL, 1'b0);
    send_beat(D2, ALL, 1'b1);
    idle(3);
    checks++; if (mq_keep.size() != 0) begin errors++; $display("FAIL drop_payload: got %0d beats want 0", mq_keep.size()); end
    checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b want 1", err_drop); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d want 1", drop_count); end
    checks++; if (cq_op.size() != 0) begin errors++; $display("FAIL drop_cmd: got %0d cmds want 0", cq_op.size()); end
  endtask

  task automatic test_overrun();
    int d0;
    d0 = done_cnt;
    clear_q();
    send_beat(first_beat(mk_hdr(2'd0, 8'd2, 1'b1, 32'd20), PAY2), ALL, 1'b0);
    send_beat(D2, ALL, 1'b1);
    idle(3);
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", err_overrun); end
    checks++; if (slot_valid !== 4'b0010) begin errors++; $display("FAIL ovr_slot: got %b want 0010", slot_valid); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL ovr_no_done: got %0d pulses want 0", done_cnt - d0); end
    checks++;
    if (cq_addr.size() != 1) begin errors++; $display("FAIL ovr_cmd_count: got %0d want 1", cq_addr.size()); end
    else if (cq_addr[0] !== 34'h200_0000 || cq_len[0] !== 32'd20) begin
      errors++; $display("FAIL ovr_cmd: got addr=%h len=%0d want addr=2000000 len=20", cq_addr[0], cq_len[0]);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [511:0] held;
    logic [511:0] exp;
    int d0;
    d0 = done_cnt;
    exp = 512'd0;
    exp[79:0] = PAY2;
    clear_q();
    m_if.tready = 1'b0;
    send_beat(first_beat(mk_hdr(2'd0, 8'd3, 1'b1, 32'd200), PAY2), ALL, 1'b0);
    @(negedge clk);
    #1;
    held = m_if.tdata;
    checks++; if (held !== exp) begin errors++; $display("FAIL stall_data: got %h want %h", held[79:0], exp[79:0]); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL stall_tready[%0d]: got %b want 0", i, s_if.tready); end
      checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== held) begin errors++; $display("FAIL stall_hold[%0d]: valid=%b data changed", i, m_if.tvalid); end
      @(negedge clk);
      #1;
    end
    m_if.tready = 1'b1;
    send_beat(D1, ALL, 1'b0);
    send_beat(D2, ALL, 1'b0);
    send_beat(D1, 64'h3FFF_FFFF_FFFF_FFFF, 1'b1);
    idle(3);
    checks++;
    if (mq_keep.size() != 4) begin errors++; $display("FAIL stall_beats: got %0d want 4", mq_keep.size()); end
    else if (mq_keep[0] !== 64'h3FF || mq_data[1] !== D1 || mq_data[2] !== D2 ||
             mq_keep[3] !== 64'h3FFF_FFFF_FFFF_FFFF || mq_last[3] !== 1'b1) begin
      errors++; $display("FAIL stall_order: got keeps %h %h %h %h want 3ff ffff.. ffff.. 3fff..", mq_keep[0], mq_keep[1], mq_keep[2], mq_keep[3]);
    end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL stall_done: got %0d pulses want 1", done_cnt - d0); end
    checks++; if (slot_valid !== 4'b1010) begin errors++; $display("FAIL stall_slot: got %b want 1010", slot_valid); end
  endtask

  task automatic test_cmd_stall();
    logic [511:0] ld;
    ld = first_beat(mk_hdr(2'd1, 8'd0, 1'b0, 32'd0), 80'd0);
    clear_q();
    cmd_ready = 1'b0;
    send_beat(first_beat(mk_hdr(2'd0, 8'd0, 1'b1, 32'd10), PAY1), ALL, 1'b1);
    @(negedge clk);
    s_if.tdata = ld; s_if.tkeep = ALL; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL cstall_tready[%0d]: got %b want 0", i, s_if.tready); end
      checks++; if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, 1'b0, 32'd10}) begin errors++; $display("FAIL cstall_hold[%0d]: valid=%b op=%b len=%0d want 1 0 10", i, cmd_valid, cmd_op, cmd_len); end
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    cmd_ready = 1'b1;
    send_beat(ld, ALL, 1'b1);
    idle(3);
    checks++;
    if (cq_op.size() != 2) begin errors++; $display("FAIL cstall_cmds: got %0d want 2", cq_op.size()); end
    else if ({cq_op[0], cq_addr[0], cq_len[0], cq_op[1], cq_addr[1], cq_len[1]} !==
             {1'b0, 34'd0, 32'd10, 1'b1, 34'd0, 32'd10}) begin
      errors++; $display("FAIL cstall_cmd_vals: got op %b/%b len %0d/%0d want 0/1 10/10", cq_op[0], cq_op[1], cq_len[0], cq_len[1]);
    end
    checks++; if (slot_valid !== 4'b1011) begin errors++; $display("FAIL cstall_slot: got %b want 1011", slot_valid); end
    checks++; if (mq_keep.size() != 1) begin errors++; $display("FAIL cstall_beats: got %0d want 1", mq_keep.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    send_beat(first_beat(mk_hdr(2'd0, 8'd1, 1'b1, 32'd100), PAY1), ALL, 1'b0);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({s_if.tready, m_if.tvalid, cmd_valid, done, err_overrun, err_drop} !== 6'd0) begin
      errors++; $display("FAIL mrst_flags: got %b want 000000", {s_if.tready, m_if.tvalid, cmd_valid, done, err_overrun, err_drop});
    end
    checks++; if ({slot_valid, drop_count} !== 20'd0) begin errors++; $display("FAIL mrst_state: slot=%b drops=%0d want 0", slot_valid, drop_count); end
    checks++; if (m_if.tkeep !== 64'd0 || cmd_len !== 32'd0 || cmd_addr !== 34'd0) begin errors++; $display("FAIL mrst_regs: keep=%h len=%0d addr=%h want 0", m_if.tkeep, cmd_len, cmd_addr); end
    rst = 1'b0;
    clear_q();
    d0 = done_cnt;
    send_beat(first_beat(mk_hdr(2'd0, 8'd2, 1'b1, 32'd74), PAY2), ALL, 1'b0);
    send_beat(D2, ALL, 1'b1);
    idle(3);
    checks++;
    if (cq_addr.size() != 1) begin errors++; $display("FAIL mrst_cmd_count: got %0d want 1", cq_addr.size()); end
    else if ({cq_op[0], cq_addr[0], cq_len[0]} !== {1'b0, 34'h200_0000, 32'd74}) begin
      errors++; $display("FAIL mrst_cmd: got op=%b addr=%h len=%0d want 0 2000000 74", cq_op[0], cq_addr[0], cq_len[0]);
    end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL mrst_done: got %0d pulses want 1", done_cnt - d0); end
    checks++; if (slot_valid !== 4'b0100) begin errors++; $display("FAIL mrst_slot: got %b want 0100", slot_valid); end
    checks++; if (mq_keep.size() != 2) begin errors++; $display("FAIL mrst_beats: got %0d want 2", mq_keep.size()); end
  endtask

  initial begin
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = 512'd0; s_if.tkeep = 64'd0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    cmd_ready = 1'b1;
    test_reset();
    test_write_header();
    test_complete_and_load();
    test_drop();
    test_overrun();
    test_back_to_back_stall();
    test_cmd_stall();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
